// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: a carry-save pair goes in and a
// resolved word plus overflow count comes out.
interface csa_resolver_if #(
    parameter int width_p = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [width_p-1:0] s_i;
    logic [width_p-1:0] c_i;
    logic               out_valid;
    logic               out_ready;
    logic [width_p-1:0] sum_o;
    logic [1:0]         ovf_o;

    modport slave (
        input  in_valid, s_i, c_i, out_ready,
        output in_ready, out_valid, sum_o, ovf_o
    );

    modport master (
        output in_valid, s_i, c_i, out_ready,
        input  in_ready, out_valid, sum_o, ovf_o
    );
endinterface

// File: rtl/csa_resolver.sv
// Digit-serial carry-propagate stage: resolves s + 2c, digit_p bits per
// cycle (LSB digit first), behind valid/ready handshakes on both sides.
module csa_resolver #(
    parameter int width_p = 16,
    parameter int digit_p = 4
) (
    input logic           clk,
    input logic           rst,
    csa_resolver_if.slave bus
);
    localparam int n_lp  = width_p / digit_p;
    localparam int kw_lp = (n_lp > 1) ? $clog2(n_lp) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((width_p % digit_p) != 0) begin : g_bad_digit
            $error("csa_resolver: width_p must be a multiple of digit_p");
        end
    endgenerate

    logic [1:0]                 state_q, state_d;
    logic [width_p-1:0]         a_q, a_d;
    logic [width_p-1:0]         b_q, b_d;
    logic [width_p-1:0]         res_q, res_d;
    logic                       cy_q, cy_d;
    logic                       hi_q, hi_d;
    logic [kw_lp-1:0]           k_q, k_d;
    logic [digit_p:0]           digit_sum;
    logic [width_p+digit_p-1:0] res_cat;

    assign digit_sum = {1'b0, a_q[digit_p-1:0]} + {1'b0, b_q[digit_p-1:0]}
                     + {{digit_p{1'b0}}, cy_q};

    // New digits enter from the MSB end so the word is LSB-aligned after N shifts.
    assign res_cat = {digit_sum[digit_p-1:0], res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        hi_d    = hi_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.s_i;
                    b_d     = bus.c_i << 1;
                    hi_d    = bus.c_i[width_p-1];
                    cy_d    = 1'b0;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d = res_cat[width_p+digit_p-1:digit_p];
                cy_d  = digit_sum[digit_p];
                a_d   = a_q >> digit_p;
                b_d   = b_q >> digit_p;
                k_d   = k_q + 1'b1;
                if (k_q == kw_lp'(n_lp - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            hi_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            hi_q    <= hi_d;
            k_q     <= k_d;
        end
    end

    // The carry is live during BUSY, so the overflow count is only exposed in DONE.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum_o     = res_q;
    assign bus.ovf_o     = (state_q == DONE) ? ({1'b0, cy_q} + {1'b0, hi_q}) : 2'b00;
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Converts a carry-save pair (sum vector `s`, carry vector `c`, as produced by the team's `csa` 3:2 compressor stage) back into a single two's-complement/binary word. It is the carry-propagate end of the CSA accumulation path in the IIR datapath. It resolves `s + (c << 1)` digit-serially, `digit_p` bits per cycle, LSB digit first, to keep the adder short. It uses a valid/ready handshake on both sides.

## Interface

Parameters:
- `width_p`, default 16: width of `s`, `c` and the resolved result. Must be a multiple of `digit_p`; otherwise elaboration fails.
- `digit_p`, default 4: bits resolved per cycle. Number of digit cycles N = `width_p/digit_p`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: `s_i`/`c_i` hold a CSA pair to resolve.
- `in_ready`, output, 1: block can accept a pair.
- `s_i`, input, `width_p`: sum vector; bit i has weight 2^i.
- `c_i`, input, `width_p`: carry vector; bit i has weight 2^(i+1).
- `out_valid`, output, 1: `sum_o`/`ovf_o` hold a resolved result.
- `out_ready`, input, 1: downstream accepts the result.
- `sum_o`, output, `width_p`: `(s + 2c) mod 2^width_p`.
- `ovf_o`, output, 2: `floor((s + 2c) / 2^width_p)`, range 0..2.

## Operation

States:
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - latch `A = s_i` and `B = {c_i[width_p-2:0], 1'b0}`;
    - latch `hi = c_i[width_p-1]`;
    - clear carry register `cy` and digit counter `k`;
    - go to BUSY.
- **BUSY**
  - Each cycle, add `A[digit_p-1:0] + B[digit_p-1:0] + cy` (`digit_p+1` bits).
  - Store the low `digit_p` bits as the next result digit: shift into the result register from the MSB end, so after N shifts it is LSB-aligned.
  - `cy` takes the adder's MSB.
  - Shift `A` and `B` right by `digit_p`; increment `k`.
  - When `k == N-1`, go to DONE on this edge.
- **DONE**
  - `out_valid` = 1; `sum_o` = result register; `ovf_o = cy + hi` (2-bit add).
  - On `out_ready`, go to IDLE.

Rules:
- `in_ready` = (state == IDLE), combinational from state. No input is accepted in BUSY or DONE; `in_valid` there is ignored and does not need to be held.
- `out_valid` = (state == DONE).
- `sum_o` and `ovf_o` are stable while `out_valid & !out_ready`.
- `sum_o` is don't-care while `out_valid` = 0, except at reset.
- Arithmetic is unsigned over the redundant pair. A signed interpretation is the caller's business; `ovf_o` is then discarded.
- `digit_p == width_p` (N = 1) is legal: BUSY lasts exactly one cycle.

Reset:
- Asynchronous assertion, at any time including mid-BUSY, forces IDLE.
- Reset values: `out_valid` = 0, `sum_o` = 0, `ovf_o` = 0.
- Internal `A`, `B`, `cy`, `hi` and `k` are cleared.
- An in-flight transaction is discarded with no output.
- `in_ready` = 1 from the first rising edge after `rst` deasserts.

## Timing

- Accept edge at cycle 0. BUSY occupies cycles 1..N. `out_valid` rises after edge N, i.e. N cycles after the accept edge.
- Minimum occupancy is N+2 cycles per transaction: accept, N digits, one DONE cycle with `out_ready` = 1. Then back in IDLE.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- Critical path is one `(digit_p+1)`-bit adder plus the `cy` feedback.

## Test plan

All cases use `width_p` = 16 and `digit_p` = 4 (N = 4) unless stated.

1. **Basic latency:** `s` = 0x1234, `c` = 0x0000.
   - `sum_o` = 0x1234, `ovf_o` = 0.
   - `out_valid` rises exactly 4 cycles after the accept edge.
   - `in_ready` = 0 from the accept edge until the return to IDLE.
2. **Cross-digit carry:**
   - `s` = 0x00FF, `c` = 0x0001 gives `sum_o` = 0x0101, `ovf_o` = 0.
   - `s` = 0xFFFF, `c` = 0x0001 gives `sum_o` = 0x0001, `ovf_o` = 1 (carry ripples through all 4 digits).
3. **Maximum value:** `s` = 0xFFFF, `c` = 0xFFFF gives `sum_o` = 0xFFFD, `ovf_o` = 2. Exercises the `hi` path.
4. **Backpressure:**
   - Hold `out_ready` = 0 for 5 cycles in DONE and toggle `in_valid` with a different pair.
   - Required: `sum_o`/`ovf_o` stable, no second accept.
   - After `out_ready` = 1, `in_ready` = 1 on the next cycle.
5. **Reset mid-BUSY:**
   - Assert `rst` asynchronously during digit 2 of `s` = 0xAAAA, `c` = 0x5555.
   - Required: `out_valid`, `sum_o` and `ovf_o` go to 0 immediately.
   - After release, `s` = 0x0003, `c` = 0x0002 gives `sum_o` = 0x0007, `ovf_o` = 0.
6. **Random and single-digit configurations:**
   - 1000 random pairs with random `out_ready` are checked against `s + 2*c` computed at `width_p+2` bits.
   - Repeat with `digit_p` = 16 (N = 1): latency 1 cycle, same results.
